// File: rtl/compcount_multi_if.sv
// Bus bundle for the multi-channel compare-counter: control/sample inputs
// travel from the sample source (master) to the counter (slave); run counts,
// hit flags, the sticky verdict and per-channel FSM state travel back.
//
// Handshake: din_valid[i] is a qualifier-only strobe with no ready/backpressure.
// A sample on channel i is consumed on every posedge where enb==1,
// din_valid[i]==1, clear==0 and mode matches the registered mode; in every
// other cycle the sample is dropped, and the source must not expect a retry.
interface compcount_multi_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CNT_W = 4
);
    logic                   enb;
    logic                   clear;
    logic [1:0]             mode;
    logic [WIDTH-1:0]       ref_val;
    logic [CNT_W-1:0]       thresh;
    logic [NCH-1:0]         din_valid;
    logic [NCH*WIDTH-1:0]   din;
    logic [NCH*CNT_W-1:0]   count;
    logic [NCH-1:0]         hit;
    logic                   all_hit;
    logic                   verdict;
    logic [NCH*2-1:0]       state;

    modport master (
        output enb, clear, mode, ref_val, thresh, din_valid, din,
        input  count, hit, all_hit, verdict, state
    );

    modport slave (
        input  enb, clear, mode, ref_val, thresh, din_valid, din,
        output count, hit, all_hit, verdict, state
    );
endinterface

// File: rtl/compcount_multi.sv
// Multi-channel compare-counter. Each channel counts consecutive valid samples
// that satisfy the selected compare (against its previous sample or ref_val),
// saturating at 2**CNT_W-1. A channel hits once primed and count >= thresh;
// verdict is a sticky OR of hits, released only by clear or reset.
// Per-channel FSM state is exported on bus.state (2 bits per channel).
module compcount_multi #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int CNT_W = 4
) (
    input logic               clk,
    input logic               rst,
    compcount_multi_if.slave  bus
);
    localparam logic [1:0] ST_UNPRIMED = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_SAT      = 2'd2;

    localparam logic [1:0] MODE_PREV = 2'b00;
    localparam logic [1:0] MODE_EQ   = 2'b01;
    localparam logic [1:0] MODE_GT   = 2'b10;
    localparam logic [1:0] MODE_LT   = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - 1'b1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]                     mode_q;
    logic [NCH-1:0][1:0]            st_q;
    logic [NCH-1:0][CNT_W-1:0]      cnt_q;
    logic [NCH-1:0][WIDTH-1:0]      prev_q;
    logic [NCH-1:0]                 hit_q;
    logic                           verdict_q;

    logic [NCH-1:0][WIDTH-1:0]      din_ch;
    logic [NCH-1:0]                 match;
    logic [NCH-1:0][1:0]            nxt_st;
    logic [NCH-1:0][CNT_W-1:0]      nxt_cnt;
    logic [NCH-1:0]                 nxt_hit;

    // Flat sample bus viewed as one slice per channel (channel i at [i*WIDTH +: WIDTH]).
    assign din_ch = bus.din;

    // Per-channel compare and next-state/next-count, applied only on an accepted sample.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            match[i]   = 1'b0;
            nxt_st[i]  = st_q[i];
            nxt_cnt[i] = cnt_q[i];
            nxt_hit[i] = 1'b0;

            case (mode_q)
                MODE_PREV: match[i] = (din_ch[i] == prev_q[i]);
                MODE_EQ:   match[i] = (din_ch[i] == bus.ref_val);
                MODE_GT:   match[i] = (din_ch[i] >  bus.ref_val);
                MODE_LT:   match[i] = (din_ch[i] <  bus.ref_val);
                default:   match[i] = 1'b0;
            endcase

            case (st_q[i])
                ST_UNPRIMED: begin
                    // First sample has no predecessor, so it only counts in reference modes.
                    nxt_st[i]  = ST_RUN;
                    nxt_cnt[i] = (mode_q != MODE_PREV && match[i]) ? CNT_ONE : '0;
                end
                ST_RUN: begin
                    if (match[i]) begin
                        nxt_cnt[i] = cnt_q[i] + 1'b1;
                        if (cnt_q[i] == CNT_PRE) begin
                            nxt_st[i] = ST_SAT;
                        end
                    end else begin
                        nxt_cnt[i] = '0;
                    end
                end
                ST_SAT: begin
                    if (!match[i]) begin
                        nxt_st[i]  = ST_RUN;
                        nxt_cnt[i] = '0;
                    end
                end
                default: begin
                    nxt_st[i]  = ST_UNPRIMED;
                    nxt_cnt[i] = '0;
                end
            endcase

            // Every accepted sample leaves the channel primed, so only the count matters.
            nxt_hit[i] = (nxt_cnt[i] >= bus.thresh);
        end
    end

    // State update: reset > clear > mode change > enable hold > sample update.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q    <= MODE_PREV;
            st_q      <= '0;
            cnt_q     <= '0;
            prev_q    <= '0;
            hit_q     <= '0;
            verdict_q <= 1'b0;
        end else if (bus.clear) begin
            mode_q    <= bus.mode;
            st_q      <= '0;
            cnt_q     <= '0;
            hit_q     <= '0;
            verdict_q <= 1'b0;
        end else if (bus.enb) begin
            if (bus.mode != mode_q) begin
                // New compare rule: old runs are meaningless, this cycle's samples are dropped.
                mode_q <= bus.mode;
                st_q   <= '0;
                cnt_q  <= '0;
                hit_q  <= '0;
            end else begin
                verdict_q <= verdict_q | (|hit_q);
                for (int i = 0; i < NCH; i++) begin
                    if (bus.din_valid[i]) begin
                        st_q[i]   <= nxt_st[i];
                        cnt_q[i]  <= nxt_cnt[i];
                        prev_q[i] <= din_ch[i];
                        hit_q[i]  <= nxt_hit[i];
                    end
                end
            end
        end
    end

    assign bus.count   = cnt_q;
    assign bus.hit     = hit_q;
    assign bus.all_hit = &hit_q;
    assign bus.verdict = verdict_q;
    assign bus.state   = st_q;
endmodule

// File: tb/tb_compcount_multi.sv
// Self-checking bench for compcount_multi: a reference model predicts every
// output after each edge, predictions are queued and compared against the DUT
// one time unit after the edge; directed scenarios are followed by a random run.
module tb_compcount_multi;
    localparam int WIDTH = 8;
    localparam int NCH   = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = 15;
    localparam int EW    = 2*NCH + 2 + NCH + NCH*CNT_W;

    logic clk;
    logic rst;

    compcount_multi_if #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) bus ();

    compcount_multi #(.WIDTH(WIDTH), .NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    int         m_cnt[NCH];
    bit         m_primed[NCH];
    logic [7:0] m_prev[NCH];
    bit         m_hit[NCH];
    bit         m_verdict;
    logic [1:0] m_mode_q;
    logic [7:0] cur_ref;
    logic [3:0] cur_thresh;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset_chans();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]    = 0;
            m_primed[i] = 1'b0;
            m_hit[i]    = 1'b0;
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input bit clr, input logic [1:0] md,
                              input logic [NCH-1:0] vld, input logic [NCH*WIDTH-1:0] d);
        bit any_hit;
        bit mt;
        logic [7:0] dv;
        if (!r) begin
            model_reset_chans();
            for (int i = 0; i < NCH; i++) m_prev[i] = 8'd0;
            m_verdict = 1'b0;
            m_mode_q  = 2'b00;
        end else if (clr) begin
            model_reset_chans();
            m_verdict = 1'b0;
            m_mode_q  = md;
        end else if (en && md != m_mode_q) begin
            model_reset_chans();
            m_mode_q = md;
        end else if (en) begin
            any_hit = 1'b0;
            for (int i = 0; i < NCH; i++) any_hit |= m_hit[i];
            if (any_hit) m_verdict = 1'b1;
            for (int i = 0; i < NCH; i++) begin
                if (vld[i]) begin
                    dv = d[i*WIDTH +: WIDTH];
                    case (m_mode_q)
                        2'b00:   mt = (dv == m_prev[i]);
                        2'b01:   mt = (dv == cur_ref);
                        2'b10:   mt = (dv >  cur_ref);
                        default: mt = (dv <  cur_ref);
                    endcase
                    if (!m_primed[i]) begin
                        m_primed[i] = 1'b1;
                        m_cnt[i]    = (m_mode_q != 2'b00 && mt) ? 1 : 0;
                    end else if (mt) begin
                        m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
                    end else begin
                        m_cnt[i] = 0;
                    end
                    m_prev[i] = dv;
                    m_hit[i]  = (m_cnt[i] >= int'(cur_thresh));
                end
            end
        end
    endtask

    function automatic logic [EW-1:0] model_pack();
        logic [NCH*CNT_W-1:0] c;
        logic [NCH-1:0]       h;
        logic [2*NCH-1:0]     s;
        logic [3:0]           cv;
        for (int i = 0; i < NCH; i++) begin
            cv = 4'(m_cnt[i]);
            c[i*CNT_W +: CNT_W] = cv;
            h[i] = m_hit[i];
            if (!m_primed[i])        s[i*2 +: 2] = 2'd0;
            else if (m_cnt[i] == CMAX) s[i*2 +: 2] = 2'd2;
            else                     s[i*2 +: 2] = 2'd1;
        end
        return {s, m_verdict, &h, h, c};
    endfunction

    task automatic compare_out(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({tag, "_count"},   32'(bus.count),   32'(e[NCH*CNT_W-1:0]));
            check_eq({tag, "_hit"},     32'(bus.hit),     32'(e[NCH*CNT_W +: NCH]));
            check_eq({tag, "_all_hit"}, 32'(bus.all_hit), 32'(e[NCH*CNT_W+NCH]));
            check_eq({tag, "_verdict"}, 32'(bus.verdict), 32'(e[NCH*CNT_W+NCH+1]));
            check_eq({tag, "_state"},   32'(bus.state),   32'(e[EW-1 -: 2*NCH]));
        end
    endtask

    // driver: apply one cycle of stimulus, predict, then compare after the edge
    task automatic step(input string tag, input bit en, input bit clr, input logic [1:0] md,
                        input logic [NCH-1:0] vld, input logic [NCH*WIDTH-1:0] d);
        bus.enb       = en;
        bus.clear     = clr;
        bus.mode      = md;
        bus.din_valid = vld;
        bus.din       = d;
        bus.ref_val   = cur_ref;
        bus.thresh    = cur_thresh;
        @(posedge clk);
        model_edge(rst, en, clr, md, vld, d);
        exp_q.push_back(model_pack());
        #1;
        compare_out(tag);
    endtask

    function automatic logic [31:0] rnd_din();
        return $urandom();
    endfunction

    initial begin
        logic [3:0] t3_cnt [4];
        logic       t3_hit [4];
        logic [7:0] v;
        logic [1:0] md;
        logic       en;
        logic       clr;

        t3_cnt = '{4'd1, 4'd0, 4'd1, 4'd2};
        t3_hit = '{1'b0, 1'b0, 1'b0, 1'b1};
        rst = 1'b0;
        cur_ref = 8'd0;
        cur_thresh = 4'd0;
        bus.enb = 1'b0; bus.clear = 1'b0; bus.mode = 2'b00;
        bus.din_valid = '0; bus.din = '0; bus.ref_val = '0; bus.thresh = '0;
        m_mode_q = 2'b00; m_verdict = 1'b0;
        model_reset_chans();
        for (int i = 0; i < NCH; i++) m_prev[i] = 8'd0;

        // T1: held in reset with valid samples
        for (int k = 0; k < 10; k++) step("t1_reset", 1'b1, 1'b0, 2'b00, 4'hF, rnd_din());
        check_eq("t1_verdict_const", 32'(bus.verdict), 32'd0);
        rst = 1'b1;

        // T2: mode 00 run on ch0 up to saturation
        cur_thresh = 4'd15;
        for (int k = 1; k <= 17; k++) begin
            step("t2_run", 1'b1, 1'b0, 2'b00, 4'b0001, {rnd_din() & 32'hFFFFFF00} | 32'h05);
            if (k == 15) check_eq("t2_hit_k15", 32'(bus.hit[0]), 32'd0);
            if (k == 16) begin
                check_eq("t2_cnt_k16", 32'(bus.count[3:0]), 32'd15);
                check_eq("t2_hit_k16", 32'(bus.hit[0]), 32'd1);
            end
        end
        check_eq("t2_cnt_hold", 32'(bus.count[3:0]), 32'd15);
        check_eq("t2_verdict", 32'(bus.verdict), 32'd1);
        step("t2_break", 1'b1, 1'b0, 2'b00, 4'b0001, 32'h08);
        check_eq("t2_cnt_break", 32'(bus.count[3:0]), 32'd0);
        check_eq("t2_verdict_held", 32'(bus.verdict), 32'd1);

        // T3: mode 10 against ref 3 on ch1
        cur_ref = 8'd3; cur_thresh = 4'd2;
        step("t3_modechg", 1'b1, 1'b0, 2'b10, 4'b0000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: v = 8'd8;
                1: v = 8'd2;
                default: v = 8'd255;
            endcase
            step("t3_gt", 1'b1, 1'b0, 2'b10, 4'b0010, {16'h0, v, 8'h0});
            check_eq($sformatf("t3_cnt%0d", k), 32'(bus.count[7:4]), 32'(t3_cnt[k]));
            check_eq($sformatf("t3_hit%0d", k), 32'(bus.hit[1]), 32'(t3_hit[k]));
        end

        // T4: all channels equal to ref, then clear
        cur_ref = 8'hFF; cur_thresh = 4'd3;
        step("t4_modechg", 1'b1, 1'b0, 2'b01, 4'b0000, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            step("t4_eq", 1'b1, 1'b0, 2'b01, 4'hF, 32'hFFFF_FFFF);
            check_eq($sformatf("t4_all_hit%0d", k), 32'(bus.all_hit), (k == 3) ? 32'd1 : 32'd0);
        end
        step("t4_clear", 1'b1, 1'b1, 2'b01, 4'hF, 32'hFFFF_FFFF);
        check_eq("t4_clear_cnt", 32'(bus.count), 32'd0);
        check_eq("t4_clear_verdict", 32'(bus.verdict), 32'd0);

        // T5: mode change mid-run, then enable freeze
        cur_thresh = 4'd5;
        step("t5_modechg", 1'b1, 1'b0, 2'b00, 4'b0000, 32'h0);
        v = 8'($urandom_range(0, 255));
        for (int k = 0; k < 8; k++) step("t5_run", 1'b1, 1'b0, 2'b00, 4'hF, {v, v, v, v});
        check_eq("t5_cnt7", 32'(bus.count), 32'h7777);
        step("t5_to_lt", 1'b1, 1'b0, 2'b11, 4'hF, {v, v, v, v});
        check_eq("t5_cnt_zero", 32'(bus.count), 32'd0);
        check_eq("t5_verdict_held", 32'(bus.verdict), 32'd1);
        cur_ref = 8'd10;
        for (int k = 0; k < 3; k++) step("t5_lt", 1'b1, 1'b0, 2'b11, 4'hF, 32'h0402_0709);
        for (int k = 0; k < 5; k++)
            step("t5_freeze", 1'b0, 1'b0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), rnd_din());
        check_eq("t5_frozen", 32'(bus.count), 32'h3333);

        // T6: reset in the middle of a run
        step("t6_modechg", 1'b1, 1'b0, 2'b00, 4'b0000, 32'h0);
        for (int k = 0; k < 13; k++) step("t6_run", 1'b1, 1'b0, 2'b00, 4'b0001, 32'h2A);
        check_eq("t6_cnt12", 32'(bus.count[3:0]), 32'd12);
        rst = 1'b0;
        step("t6_rst", 1'b1, 1'b0, 2'b00, 4'b0001, 32'h2A);
        check_eq("t6_rst_state", 32'(bus.state), 32'd0);
        rst = 1'b1;
        step("t6_first", 1'b1, 1'b0, 2'b00, 4'b0001, 32'h2A);
        check_eq("t6_first_cnt", 32'(bus.count[3:0]), 32'd0);

        // random mix of samples, mode changes, clears, freezes and threshold moves
        md = 2'b00;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 19) == 0) md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) cur_thresh = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) cur_ref = 8'($urandom_range(0, 3));
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 149) != 0);
            step("rnd", en, clr, md, 4'($urandom_range(0, 15)),
                 {6'd0, 2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3)),
                  6'd0, 2'($urandom_range(0, 3)), 6'd0, 2'($urandom_range(0, 3))});
        end
        rst = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
